// File: rtl/alarm_snooze_ctrl.sv
// Alarm life-cycle sequencer: arm, ring, snooze, stop and auto-timeout with a gated beep.
// Latency: input edges sampled at clock edge k change state/outputs right after edge k (all outputs registered).
// Backpressure: none; buttons and alarm match are edge-detected, each edge acts exactly once.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   minutes[5:0]       current minutes from the clock core; any change is one "tick"
//   alarm_hit          core alarm match level; only its rising edge starts a ring
//   arm                alarm enable switch (level); low forces IDLE from any state
//   snooze_btn         debounced snooze button (edge-detected)
//   stop_btn           debounced stop button (edge-detected)
//   buzzer             beep waveform, high on ring entry, toggles every BEEP_DIV cycles
//   state[1:0]         IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
//   snooze_count[2:0]  snoozes used in the current alarm event
//   missed             sticky flag, set when ringing timed out unattended

module alarm_snooze_ctrl #(
    parameter int SNOOZE_MIN       = 5,   // 1..15
    parameter int RING_TIMEOUT_MIN = 10,  // 1..15
    parameter int MAX_SNOOZE       = 3,   // 0..7
    parameter int BEEP_DIV         = 16   // >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] minutes,
    input  logic       alarm_hit,
    input  logic       arm,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic [1:0] state,
    output logic [2:0] snooze_count,
    output logic       missed
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RINGING = 2'd2,
        ST_SNOOZE  = 2'd3
    } state_t;

    localparam int          BEEP_W     = $clog2(BEEP_DIV);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_DIV - 1);
    localparam logic [3:0]  SNZ_RELOAD = 4'(SNOOZE_MIN);
    localparam logic [3:0]  RING_LIMIT = 4'(RING_TIMEOUT_MIN);
    localparam logic [2:0]  SNZ_MAX    = 3'(MAX_SNOOZE);

    state_t              state_q;
    logic [5:0]          minutes_q;
    logic                alarm_q;
    logic                snooze_q;
    logic                stop_q;
    logic [3:0]          ring_min;
    logic [3:0]          snz_left;
    logic [BEEP_W-1:0]   beep_cnt;
    logic                buzzer_q;
    logic [2:0]          snooze_count_q;
    logic                missed_q;

    logic                tick;
    logic                hit_rise;
    logic                snz_rise;
    logic                stop_rise;
    logic [3:0]          ring_min_inc;
    logic [BEEP_W-1:0]   beep_cnt_nxt;
    logic                buzzer_nxt;

    // Edge detectors run in every state. Because alarm_q always tracks
    // alarm_hit, arming while the match is already high produces no edge,
    // so the controller waits for the next match.
    assign tick      = (minutes != minutes_q);
    assign hit_rise  = alarm_hit  & ~alarm_q;
    assign snz_rise  = snooze_btn & ~snooze_q;
    assign stop_rise = stop_btn   & ~stop_q;

    assign ring_min_inc = ring_min + 4'd1;

    // Beep pattern while staying in RINGING: count 0..BEEP_DIV-1, flip on wrap.
    always_comb begin
        beep_cnt_nxt = beep_cnt + 1'b1;
        buzzer_nxt   = buzzer_q;
        if (beep_cnt == BEEP_LAST) begin
            beep_cnt_nxt = '0;
            buzzer_nxt   = ~buzzer_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            minutes_q      <= '0;
            alarm_q        <= 1'b0;
            snooze_q       <= 1'b0;
            stop_q         <= 1'b0;
            ring_min       <= '0;
            snz_left       <= '0;
            beep_cnt       <= '0;
            buzzer_q       <= 1'b0;
            snooze_count_q <= '0;
            missed_q       <= 1'b0;
        end else begin
            minutes_q <= minutes;
            alarm_q   <= alarm_hit;
            snooze_q  <= snooze_btn;
            stop_q    <= stop_btn;

            // Clear first; a timeout in the same cycle overrides below.
            if (stop_rise || !arm) begin
                missed_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_q <= ST_ARMED;
                    end
                end

                ST_ARMED: begin
                    if (!arm) begin
                        state_q <= ST_IDLE;
                    end else if (hit_rise) begin
                        state_q        <= ST_RINGING;
                        snooze_count_q <= '0;
                        ring_min       <= '0;
                        beep_cnt       <= '0;
                        buzzer_q       <= 1'b1;
                    end
                end

                ST_RINGING: begin
                    if (!arm) begin
                        state_q  <= ST_IDLE;
                        buzzer_q <= 1'b0;
                    end else if (stop_rise) begin
                        state_q        <= ST_ARMED;
                        snooze_count_q <= '0;
                        buzzer_q       <= 1'b0;
                    end else if (snz_rise) begin
                        if (snooze_count_q < SNZ_MAX) begin
                            state_q        <= ST_SNOOZE;
                            snooze_count_q <= snooze_count_q + 3'd1;
                            snz_left       <= SNZ_RELOAD;
                            buzzer_q       <= 1'b0;
                        end else begin
                            // Snooze budget used up: keep ringing, timeout
                            // progress is preserved and the edge consumes any tick.
                            beep_cnt <= beep_cnt_nxt;
                            buzzer_q <= buzzer_nxt;
                        end
                    end else begin
                        beep_cnt <= beep_cnt_nxt;
                        buzzer_q <= buzzer_nxt;
                        if (tick) begin
                            if (ring_min_inc == RING_LIMIT) begin
                                state_q        <= ST_ARMED;
                                missed_q       <= 1'b1;
                                snooze_count_q <= '0;
                                buzzer_q       <= 1'b0;
                            end else begin
                                ring_min <= ring_min_inc;
                            end
                        end
                    end
                end

                ST_SNOOZE: begin
                    // A new alarm match while snoozing is deliberately ignored.
                    if (!arm) begin
                        state_q <= ST_IDLE;
                    end else if (stop_rise) begin
                        state_q        <= ST_ARMED;
                        snooze_count_q <= '0;
                    end else if (tick) begin
                        snz_left <= snz_left - 4'd1;
                        if (snz_left == 4'd1) begin
                            state_q  <= ST_RINGING;
                            ring_min <= '0;
                            beep_cnt <= '0;
                            buzzer_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state        = state_q;
    assign buzzer       = buzzer_q;
    assign snooze_count = snooze_count_q;
    assign missed       = missed_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Testbench for alarm_snooze_ctrl: directed life-cycle scenarios followed by random input traffic.
// Latency: outputs compared 1 time unit after every rising edge against a cycle-level reference model.
// Backpressure: not applicable; one input changes per cycle in the random phase.

module tb_alarm_snooze_ctrl;

    localparam int SNOOZE_MIN       = 5;
    localparam int RING_TIMEOUT_MIN = 10;
    localparam int MAX_SNOOZE       = 3;
    localparam int BEEP_DIV         = 16;

    logic       clk;
    logic       rst_n;
    logic [5:0] minutes;
    logic       alarm_hit;
    logic       arm;
    logic       snooze_btn;
    logic       stop_btn;
    logic       buzzer;
    logic [1:0] state;
    logic [2:0] snooze_count;
    logic       missed;

    int errs;
    int checks;

    alarm_snooze_ctrl #(
        .SNOOZE_MIN      (SNOOZE_MIN),
        .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN),
        .MAX_SNOOZE      (MAX_SNOOZE),
        .BEEP_DIV        (BEEP_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .minutes     (minutes),
        .alarm_hit   (alarm_hit),
        .arm         (arm),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .buzzer      (buzzer),
        .state       (state),
        .snooze_count(snooze_count),
        .missed      (missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (plain integers) ----------------
    // Buzzer is derived from the number of cycles spent ringing since entry:
    // high in even BEEP_DIV-long windows, low in odd ones.
    int m_state;
    int m_cnt;
    int m_ring_min;
    int m_snz_left;
    int m_ring_cycles;
    int m_missed;
    int p_min, p_hit, p_snz, p_stop;

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_ring_min = 0; m_snz_left = 0;
        m_ring_cycles = 0; m_missed = 0;
        p_min = 0; p_hit = 0; p_snz = 0; p_stop = 0;
    endtask

    function automatic int model_buzzer();
        if (m_state != 2) return 0;
        return ((m_ring_cycles / BEEP_DIV) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic model_step();
        bit tk, hr, zr, sr;
        tk = (int'(minutes) != p_min);
        hr = alarm_hit  && (p_hit  == 0);
        zr = snooze_btn && (p_snz  == 0);
        sr = stop_btn   && (p_stop == 0);
        p_min = int'(minutes); p_hit = int'(alarm_hit);
        p_snz = int'(snooze_btn); p_stop = int'(stop_btn);
        if (sr || !arm) m_missed = 0;
        if (m_state != 0 && !arm) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (arm) m_state = 1;
                1: if (hr) begin
                    m_state = 2; m_cnt = 0; m_ring_min = 0; m_ring_cycles = 0;
                end
                2: begin
                    if (sr) begin
                        m_state = 1; m_cnt = 0;
                    end else if (zr && m_cnt < MAX_SNOOZE) begin
                        m_state = 3; m_cnt++; m_snz_left = SNOOZE_MIN;
                    end else begin
                        m_ring_cycles++;
                        if (!zr && tk) begin
                            m_ring_min++;
                            if (m_ring_min >= RING_TIMEOUT_MIN) begin
                                m_state = 1; m_missed = 1; m_cnt = 0;
                            end
                        end
                    end
                end
                default: begin
                    if (sr) begin
                        m_state = 1; m_cnt = 0;
                    end else if (tk) begin
                        m_snz_left--;
                        if (m_snz_left == 0) begin
                            m_state = 2; m_ring_min = 0; m_ring_cycles = 0;
                        end
                    end
                end
            endcase
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".state"},  int'(state),        m_state);
        chk({tag, ".buzzer"}, int'(buzzer),       model_buzzer());
        chk({tag, ".count"},  int'(snooze_count), m_cnt);
        chk({tag, ".missed"}, int'(missed),       m_missed);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        cmp_all(tag);
    endtask

    task automatic bump(input string tag);
        minutes = 6'((int'(minutes) + 1) % 60);
        cycle(tag);
        cycle(tag);
    endtask

    task automatic press_snooze(input string tag);
        snooze_btn = 1'b1; cycle(tag);
        snooze_btn = 1'b0; cycle(tag);
    endtask

    task automatic press_stop(input string tag);
        stop_btn = 1'b1; cycle(tag);
        stop_btn = 1'b0; cycle(tag);
    endtask

    task automatic ring_edge(input string tag);
        alarm_hit = 1'b1; cycle(tag);
        alarm_hit = 1'b0; cycle(tag);
    endtask

    initial begin
        errs = 0; checks = 0;
        rst_n = 1'b0; minutes = 6'd0; alarm_hit = 1'b0; arm = 1'b0;
        snooze_btn = 1'b0; stop_btn = 1'b0;
        model_reset();
        #22;
        cmp_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Arm and ring.
        arm = 1'b1; cycle("arm");
        chk("armed", int'(state), 1);
        alarm_hit = 1'b1; cycle("hit");
        chk("ring_entry_state", int'(state), 2);
        chk("ring_entry_buzz", int'(buzzer), 1);
        alarm_hit = 1'b0;
        for (int i = 0; i < 40; i++) cycle("beep");

        // Snooze, then five minute changes bring the ring back.
        press_snooze("snz1");
        chk("snz1_state", int'(state), 3);
        chk("snz1_count", int'(snooze_count), 1);
        for (int i = 0; i < 4; i++) bump("snz1_wait");
        chk("snz1_still", int'(state), 3);
        bump("snz1_end");
        chk("rering_state", int'(state), 2);

        // Use up the snooze budget; the extra press is ignored.
        for (int s = 0; s < 2; s++) begin
            press_snooze("snzn");
            for (int i = 0; i < 5; i++) bump("snzn_wait");
        end
        chk("cap_count_pre", int'(snooze_count), 3);
        press_snooze("snz4");
        chk("cap_state", int'(state), 2);
        chk("cap_count", int'(snooze_count), 3);
        press_stop("stop");
        chk("stop_state", int'(state), 1);
        chk("stop_count", int'(snooze_count), 0);

        // Unattended ringing times out; minutes cross the 59->0 wrap on the way.
        minutes = 6'd55;
        cycle("preset_min");
        ring_edge("to_ring");
        for (int i = 0; i < 9; i++) bump("to_wait");
        chk("to_still", int'(state), 2);
        bump("to_end");
        chk("to_state", int'(state), 1);
        chk("to_missed", int'(missed), 1);
        press_stop("missed_clr");
        chk("missed_clr", int'(missed), 0);

        // Disarm during snooze; re-arm with the match already high.
        ring_edge("ring3");
        press_snooze("snz_disarm");
        arm = 1'b0; cycle("disarm");
        chk("disarm_state", int'(state), 0);
        chk("disarm_buzz", int'(buzzer), 0);
        alarm_hit = 1'b1; cycle("hold_hit");
        arm = 1'b1;
        for (int i = 0; i < 5; i++) cycle("rearm_held");
        chk("rearm_no_ring", int'(state), 1);
        alarm_hit = 1'b0; cycle("hit_low");
        alarm_hit = 1'b1; cycle("hit_again");
        chk("rearm_ring", int'(state), 2);
        alarm_hit = 1'b0;
        for (int i = 0; i < 3; i++) cycle("ring_more");

        // Asynchronous reset mid-ring, observed between clock edges.
        @(posedge clk);
        model_step();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_state",  int'(state),        0);
        chk("arst_buzz",   int'(buzzer),       0);
        chk("arst_count",  int'(snooze_count), 0);
        chk("arst_missed", int'(missed),       0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic: at most one input changes per cycle.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                if (arm) begin
                    if ($urandom_range(0, 3) == 0) arm = 1'b0;
                end else begin
                    arm = 1'b1;
                end
            end else if (r < 14) begin
                alarm_hit = ~alarm_hit;
            end else if (r < 24) begin
                snooze_btn = ~snooze_btn;
            end else if (r < 29) begin
                stop_btn = ~stop_btn;
            end else if (r < 50) begin
                minutes = 6'((int'(minutes) + int'($urandom_range(1, 3))) % 60);
            end
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alarm_snooze_ctrl.md
# alarm_snooze_ctrl

Alarm sequencing controller sitting beside the clock/alarm core in the alarm-clock top level. It watches the core's current-time minutes and raw alarm-match level, and runs the alarm life cycle: arm, ring, snooze, stop and auto-timeout. It also drives a gated beep pattern for the buzzer pin and exposes state for the status LEDs.

## Interface
Parameters:
- SNOOZE_MIN, 5: minutes spent in snooze before re-ringing; legal range 1..15.
- RING_TIMEOUT_MIN, 10: minutes of unattended ringing before auto-stop; legal range 1..15.
- MAX_SNOOZE, 3: snoozes allowed per alarm event; legal range 0..7.
- BEEP_DIV, 16: clock cycles per buzzer half-period; must be ≥2.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous, active-low reset.
- minutes, input, 6: current minutes from the clock core.
- alarm_hit, input, 1: core alarm output; high while current time equals the alarm time.
- arm, input, 1: alarm enable switch (level).
- snooze_btn, input, 1: snooze button, synchronous and debounced upstream.
- stop_btn, input, 1: stop button, synchronous and debounced upstream.
- buzzer, output, 1: beep waveform.
- state, output, 2: controller state, encoded IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
- snooze_count, output, 3: snoozes used in the current alarm event.
- missed, output, 1: sticky flag, set when ringing timed out.

## Operation
Internal registers:
- minutes_q, alarm_q, snooze_q, stop_q: previous-cycle samples of the corresponding inputs.
- tick = (minutes != minutes_q).
- hit_rise, snz_rise, stop_rise: rising edges, each computed as input & ~previous sample.
- ring_min[3:0], snz_left[3:0], beep_cnt.

Edge detectors run in every state. Asserting arm while alarm_hit is already high does not ring; the controller waits for the next match.

State transitions, listed in priority order within each state:
- IDLE:
  - arm=1 → ARMED.
- ARMED:
  - arm=0 → IDLE.
  - hit_rise → RINGING; on this transition snooze_count=0, ring_min=0, beep_cnt=0.
- RINGING:
  - arm=0 → IDLE.
  - stop_rise → ARMED; snooze_count cleared.
  - snz_rise with snooze_count<MAX_SNOOZE → SNOOZE; snooze_count+1, snz_left=SNOOZE_MIN.
  - snz_rise with snooze_count==MAX_SNOOZE → ignored; stays RINGING and ring_min is not reset.
  - tick → ring_min+1. If ring_min+1==RING_TIMEOUT_MIN → ARMED; missed set; snooze_count cleared.
- SNOOZE:
  - arm=0 → IDLE.
  - stop_rise → ARMED; snooze_count cleared.
  - tick → snz_left−1. If the result is 0 → RINGING; ring_min=0, beep_cnt=0.
  - hit_rise is ignored.

Buzzer:
- Outside RINGING: buzzer=0.
- On entry to RINGING: buzzer=1.
- In RINGING: beep_cnt counts 0..BEEP_DIV−1; buzzer toggles when beep_cnt wraps.

missed:
- Cleared by stop_rise in any state, or by arm=0.
- Set at timeout; set takes precedence over clear in the same cycle.

Arithmetic:
- Counters do not wrap in normal use because the parameter ranges bound them.
- ring_min and snz_left are 4 bits; snooze_count is 3 bits and saturates at MAX_SNOOZE.

## Timing
- Reset values: state=IDLE, buzzer=0, snooze_count=0, missed=0, all counters and sample registers 0.
- Because minutes_q resets to 0, a spurious tick is possible on the first cycle after reset. It is harmless because the controller is in IDLE.
- All outputs are registered.
- An input edge that is present at clock edge k, with the previous sample low, changes state at edge k. The new state is visible after edge k.
- Each input edge produces exactly one action. Holding a button does not repeat the action.
- A tick arriving in the same cycle as snz_rise or stop_rise is consumed by the button transition; no counter update occurs.
- Reset asserted mid-ring forces buzzer=0 and state=IDLE immediately, since reset is asynchronous.
- A minutes wrap from 59 to 0 counts as one tick.

## Test plan
- Arm, then raise alarm_hit → state=2 one cycle later. buzzer=1, then toggles every 16 cycles.
- Ringing, pulse snooze_btn, then change minutes 5 times → state=3 with snooze_count=1. On the 5th change state returns to 2 and buzzer restarts high.
- Snooze 3 times, then pulse snooze a 4th time → state stays 2 and snooze_count=3. A following stop_btn → state=1, snooze_count=0.
- Ring with no buttons through 10 minute changes → state=1 and missed=1. A stop_btn pulse → missed=0.
- arm=0 during SNOOZE → state=0 and buzzer=0. Re-arm while alarm_hit is held high → no ring until alarm_hit falls and rises again.
- Assert rst_n=0 mid-ring → buzzer, state, snooze_count and missed all read 0 immediately, with no clock edge needed.
